// File: rtl/sipo_framer_pkg.sv
// Shared definitions for the sipo_framer deserialiser: FSM state encoding,
// bit-order constants and the counter width helper.
package sipo_framer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    // Width of the bit counter for a given word width (never below one bit).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_framer_if.sv
// Serial-in / parallel-out bus: serial source and word consumer on the
// master side, the deserialiser on the slave side.
interface sipo_framer_if #(
    parameter int WIDTH = 4
);
    import sipo_framer_pkg::*;

    localparam int CNT_W = cnt_w(WIDTH);

    logic             sin;
    logic             sin_en;
    logic             sync;
    logic             out_ready;
    logic             clr_overrun;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_q;

    modport master (
        output sin, sin_en, sync, out_ready, clr_overrun,
        input  data_out, out_valid, overrun, bit_cnt, shift_q
    );

    modport slave (
        input  sin, sin_en, sync, out_ready, clr_overrun,
        output data_out, out_valid, overrun, bit_cnt, shift_q
    );

endinterface

// File: rtl/sipo_framer_shift_core.sv
// Parametrised shift register. clr zeroes the register before the shift is
// applied, so clr together with en yields a fresh word holding only sin.
// The next-state value is exported so the parent can capture a completed
// word on the same edge that shifts in its last bit.
module sipo_framer_shift_core
    import sipo_framer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = ORDER_LSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] base;

    // Next value: optional clear, then insert sin at the end chosen by bit order.
    always_comb begin
        base   = clr ? '0 : q;
        q_next = base;
        if (en) begin
            if (MSB_FIRST == ORDER_MSB_FIRST) begin
                q_next = {base[WIDTH-2:0], sin};
            end else begin
                q_next = {sin, base[WIDTH-1:1]};
            end
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_framer.sv
// Serial-in/parallel-out framer: optional sync alignment, bit counting,
// word capture with valid/ready handshake and sticky overrun flag.
module sipo_framer
    import sipo_framer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = ORDER_LSB_FIRST,
    parameter bit NEED_SYNC = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    sipo_framer_if.slave bus
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    // Without sync alignment the block comes out of reset already shifting.
    localparam state_t           ST_RESET = NEED_SYNC ? ST_IDLE : ST_SHIFT;

    state_t           state;
    state_t           state_nx;
    logic             shift_en;
    logic             complete;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_cur;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovr_q;

    sipo_framer_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (shift_en),
        .clr    (bus.sync),
        .sin    (bus.sin),
        .q      (shift_cur),
        .q_next (shift_next)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and shift qualifier: IDLE only accepts a bit that arrives with sync.
    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.sync) begin
                    state_nx = ST_SHIFT;
                    shift_en = bus.sin_en;
                end
            end
            ST_SHIFT: begin
                shift_en = bus.sin_en;
            end
            default: begin
                state_nx = ST_RESET;
            end
        endcase
    end

    // A sync bit always starts a new word, so it can never complete one.
    assign complete = shift_en && !bus.sync && (bit_cnt == CNT_LAST);

    // Bit counter: restarts on sync, wraps only on word completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (bus.sync) begin
            bit_cnt <= shift_en ? CNT_W'(1) : '0;
        end else if (complete) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Word capture and valid handshake; completion outranks consumption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (complete) begin
            data_q  <= shift_next;
            valid_q <= 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun: set when an unconsumed word is overwritten; set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else if (complete && valid_q && !bus.out_ready) begin
            ovr_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.bit_cnt   = bit_cnt;
    assign bus.shift_q   = shift_cur;

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench for sipo_framer: three 4-bit instances (LSB-first, MSB-first,
// LSB-first with sync alignment) share one stimulus stream. Expected words are
// built from the transmitted bits and queued, then popped on completion.
module tb_sipo_framer;
    import sipo_framer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    sipo_framer_if #(.WIDTH(4)) bus_a ();
    sipo_framer_if #(.WIDTH(4)) bus_b ();
    sipo_framer_if #(.WIDTH(4)) bus_c ();

    sipo_framer #(.WIDTH(4), .MSB_FIRST(1'b0), .NEED_SYNC(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    sipo_framer #(.WIDTH(4), .MSB_FIRST(1'b1), .NEED_SYNC(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));
    sipo_framer #(.WIDTH(4), .MSB_FIRST(1'b0), .NEED_SYNC(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic en, input logic sy,
                         input logic rdy, input logic clr);
        bus_a.sin = s; bus_a.sin_en = en; bus_a.sync = sy; bus_a.out_ready = rdy; bus_a.clr_overrun = clr;
        bus_b.sin = s; bus_b.sin_en = en; bus_b.sync = sy; bus_b.out_ready = rdy; bus_b.clr_overrun = clr;
        bus_c.sin = s; bus_c.sin_en = en; bus_c.sync = sy; bus_c.out_ready = rdy; bus_c.clr_overrun = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag, input logic [3:0] d, input logic v,
                            input logic o, input logic [1:0] c, input logic [3:0] q);
        chk({tag, "_data"}, 32'(d), 32'(0));
        chk({tag, "_vld"},  32'(v), 32'(0));
        chk({tag, "_ovr"},  32'(o), 32'(0));
        chk({tag, "_cnt"},  32'(c), 32'(0));
        chk({tag, "_sq"},   32'(q), 32'(0));
    endtask

    // Sends one 4-bit word; bits[i] is the i-th bit on the wire. rdy/clr/exp_vld
    // are per-edge vectors indexed by bit position.
    task automatic feed(input logic [3:0] bits, input logic [3:0] rdy, input logic [3:0] clr,
                        input logic [3:0] exp_vld, input logic exp_ovr, input bit first_sync,
                        input bit with_c, input bit chk_sq,
                        input logic [15:0] sq_a, input logic [15:0] sq_b);
        logic [3:0] wa;
        logic [3:0] wb;
        logic [3:0] ea;
        logic [3:0] eb;
        for (int i = 0; i < 4; i++) begin
            wa[i]     = bits[i];
            wb[3 - i] = bits[i];
        end
        qa.push_back(wa);
        qb.push_back(wb);
        for (int i = 0; i < 4; i++) begin
            drive(bits[i], 1'b1, first_sync && (i == 0), rdy[i], clr[i]);
            tick();
            chk("a_cnt", 32'(bus_a.bit_cnt), 32'((i + 1) % 4));
            chk("b_cnt", 32'(bus_b.bit_cnt), 32'((i + 1) % 4));
            chk("a_vld", 32'(bus_a.out_valid), 32'(exp_vld[i]));
            chk("b_vld", 32'(bus_b.out_valid), 32'(exp_vld[i]));
            if (with_c) begin
                chk("c_cnt", 32'(bus_c.bit_cnt), 32'((i + 1) % 4));
                chk("c_vld", 32'(bus_c.out_valid), 32'(exp_vld[i]));
            end
            if (chk_sq) begin
                chk("a_sq_step", 32'(bus_a.shift_q), 32'(sq_a[4*i +: 4]));
                chk("b_sq_step", 32'(bus_b.shift_q), 32'(sq_b[4*i +: 4]));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_word", 32'(bus_a.data_out), 32'(ea));
        chk("b_word", 32'(bus_b.data_out), 32'(eb));
        chk("a_sq",   32'(bus_a.shift_q),  32'(ea));
        chk("b_sq",   32'(bus_b.shift_q),  32'(eb));
        chk("a_ovr",  32'(bus_a.overrun),  32'(exp_ovr));
        chk("b_ovr",  32'(bus_b.overrun),  32'(exp_ovr));
        if (with_c) begin
            chk("c_word", 32'(bus_c.data_out), 32'(ea));
            chk("c_ovr",  32'(bus_c.overrun),  32'(exp_ovr));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_zero("rst_a", bus_a.data_out, bus_a.out_valid, bus_a.overrun, bus_a.bit_cnt, bus_a.shift_q);
        chk_zero("rst_b", bus_b.data_out, bus_b.out_valid, bus_b.overrun, bus_b.bit_cnt, bus_b.shift_q);
        chk_zero("rst_c", bus_c.data_out, bus_c.out_valid, bus_c.overrun, bus_c.bit_cnt, bus_c.shift_q);
        reset = 1'b0;

        // First word 1,1,0,1 with step-by-step shift register contents.
        feed(4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1,
             16'b1011_0110_1100_1000, 16'b1101_0110_0011_0001);

        // Second word 0,0,1,1 unconsumed: overwrite and overrun.
        feed(4'b1100, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // sin_en low holds everything.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hold_cnt",  32'(bus_a.bit_cnt),  32'(0));
        chk("hold_sq",   32'(bus_a.shift_q),  32'(4'b1100));
        chk("hold_data", 32'(bus_a.data_out), 32'(4'b1100));

        // Clear overrun; the word stays put.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_ovr",  32'(bus_a.overrun),   32'(0));
        chk("clr_data", 32'(bus_a.data_out),  32'(4'b1100));
        chk("clr_vld",  32'(bus_a.out_valid), 32'(1));

        // Overrun set coincident with clr_overrun: set wins.
        feed(4'b0101, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Consume and clear, then stream with out_ready held high.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cons_vld", 32'(bus_a.out_valid), 32'(0));
        chk("cons_ovr", 32'(bus_a.overrun),   32'(0));
        feed(4'b0110, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        feed(4'b1001, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        // Completion on the same edge as consumption keeps valid without overrun.
        feed(4'b1100, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Consume, then a mid-word sync discards two bits silently.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("cons2_vld", 32'(bus_a.out_valid), 32'(0));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid_cnt_a", 32'(bus_a.bit_cnt), 32'(2));
        chk("mid_cnt_b", 32'(bus_b.bit_cnt), 32'(2));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sync_cnt_a", 32'(bus_a.bit_cnt),   32'(0));
        chk("sync_sq_a",  32'(bus_a.shift_q),   32'(0));
        chk("sync_vld_a", 32'(bus_a.out_valid), 32'(0));
        chk("sync_ovr_a", 32'(bus_a.overrun),   32'(0));
        chk("sync_cnt_b", 32'(bus_b.bit_cnt),   32'(0));
        feed(4'b0001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Asynchronous reset mid-word, with a pending word, clears outputs at once.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_rst_cnt", 32'(bus_a.bit_cnt),   32'(2));
        chk("pre_rst_vld", 32'(bus_a.out_valid), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_zero("arst_a", bus_a.data_out, bus_a.out_valid, bus_a.overrun, bus_a.bit_cnt, bus_a.shift_q);
        chk_zero("arst_b", bus_b.data_out, bus_b.out_valid, bus_b.overrun, bus_b.bit_cnt, bus_b.shift_q);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Sync-aligned instance ignores sin_en until the first sync.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2) == 0, 1'b0, 1'b0, 1'b0);
            tick();
            chk("idle_cnt_c", 32'(bus_c.bit_cnt),   32'(0));
            chk("idle_sq_c",  32'(bus_c.shift_q),   32'(0));
            chk("idle_vld_c", 32'(bus_c.out_valid), 32'(0));
        end
        feed(4'b0001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
